not_bus_pipe: RTL

//  Parametrised, pipelined successor to the single-bit NOT gate.

---
 rtl/not_bus_pipe.sv | 69 ++++++
 1 files changed

// File: rtl/not_bus_pipe.sv
// Programmable per-bit inversion (out = in ^ mask) on a WIDTH-bit stream,
// carried through a STAGES-deep valid/ready elastic pipeline.
module not_bus_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_MASK = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic [WIDTH-1:0] mask_q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [STAGES-1:0] vld_p;
  logic [WIDTH-1:0]  data_p [STAGES];
  logic [STAGES-1:0] adv;

  function automatic logic [WIDTH-1:0] apply_mask(input logic [WIDTH-1:0] d,
                                                  input logic [WIDTH-1:0] m);
    return d ^ m;
  endfunction

  // Advance chain: a stage may load when it is empty or its successor advances.
  always_comb begin
    logic a;
    adv = '0;
    a = ~vld_p[STAGES-1] | out_ready;
    adv[STAGES-1] = a;
    for (int s = int'(STAGES) - 2; s >= 0; s--) begin
      a = ~vld_p[s] | a;
      adv[s] = a;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_p[STAGES-1];
  assign out_data  = data_p[STAGES-1];

  // Stage 0 capture applies the mask held before this edge, so a beat accepted
  // on the same edge as a mask write still sees the old mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p  <= '0;
      mask_q <= RESET_MASK;
      for (int s = 0; s < int'(STAGES); s++) data_p[s] <= '0;
    end else begin
      if (cfg_we) mask_q <= cfg_mask;
      if (adv[0]) begin
        vld_p[0]  <= in_valid;
        data_p[0] <= apply_mask(in_data, mask_q);
      end
      // Stage boundaries p(s-1) -> p(s)
      for (int s = 1; s < int'(STAGES); s++) begin
        if (adv[s]) begin
          vld_p[s]  <= vld_p[s-1];
          data_p[s] <= data_p[s-1];
        end
      end
    end
  end

endmodule
